// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard controller (PC, IF/ID, ID/EX); optional counters under HZU_PERF_EN
package riscv_pkg;
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } HAZARD_ctrl;
endpackage

module hazard_unit
  import riscv_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        EN,
  input  logic        BRANCH_cond_in,
  input  logic        IMEM_RVALID_in,
  input  logic [4:0]  ID_RS1_in,
  input  logic [4:0]  ID_RS2_in,
  input  logic        ID_USE_RS1_in,
  input  logic        ID_USE_RS2_in,
  input  logic [4:0]  EX_RD_in,
  input  logic        EX_REGWR_in,
  input  logic        EX_MEMRD_in,
  input  logic [4:0]  MEM_RD_in,
  input  logic        MEM_REGWR_in,
  output HAZARD_ctrl  HZ_PC_out,
  output HAZARD_ctrl  HZ_IFID_out,
  output HAZARD_ctrl  HZ_IDEX_out
`ifdef HZU_PERF_EN
  ,
  output logic [CNT_W-1:0] STALL_CNT_out,
  output logic [CNT_W-1:0] FLUSH_CNT_out
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("hazard_unit: CNT_W must be at least 1");
  end

  typedef enum logic {
    S_RUN     = 1'b0,
    S_DISCARD = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic m_ex1, m_ex2, m_mem1, m_mem2;
  logic dh;

  // x0 is hardwired, so a write to it can never create a dependency
  assign m_ex1  = ID_USE_RS1_in & EX_REGWR_in  & (EX_RD_in  != 5'd0) & (ID_RS1_in == EX_RD_in);
  assign m_ex2  = ID_USE_RS2_in & EX_REGWR_in  & (EX_RD_in  != 5'd0) & (ID_RS2_in == EX_RD_in);
  assign m_mem1 = ID_USE_RS1_in & MEM_REGWR_in & (MEM_RD_in != 5'd0) & (ID_RS1_in == MEM_RD_in);
  assign m_mem2 = ID_USE_RS2_in & MEM_REGWR_in & (MEM_RD_in != 5'd0) & (ID_RS2_in == MEM_RD_in);

  assign dh = (FWD_EN != 0) ? (EX_MEMRD_in & (m_ex1 | m_ex2))
                            : (m_ex1 | m_ex2 | m_mem1 | m_mem2);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state <= S_RUN;
    end else if (EN) begin
      state <= state_nxt;
    end
  end

  // A redirect with no response yet leaves a wrong-path fetch in flight
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (BRANCH_cond_in && !IMEM_RVALID_in) begin
          state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (IMEM_RVALID_in) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    HZ_PC_out   = NONE;
    HZ_IFID_out = NONE;
    HZ_IDEX_out = NONE;
    if (!RSTn) begin
      HZ_PC_out   = FLUSH;
      HZ_IFID_out = FLUSH;
      HZ_IDEX_out = FLUSH;
    end else if (!EN) begin
      HZ_PC_out   = STALL;
      HZ_IFID_out = STALL;
      HZ_IDEX_out = STALL;
    end else if (BRANCH_cond_in) begin
      HZ_PC_out   = NONE;
      HZ_IFID_out = FLUSH;
      HZ_IDEX_out = FLUSH;
    end else begin
      case (state)
        S_RUN: begin
          if (dh) begin
            HZ_PC_out   = STALL;
            HZ_IFID_out = STALL;
            HZ_IDEX_out = FLUSH;
          end else if (!IMEM_RVALID_in) begin
            HZ_PC_out   = STALL;
            HZ_IFID_out = FLUSH;
            HZ_IDEX_out = NONE;
          end
        end
        S_DISCARD: begin
          // the stale response, if it arrives now, is dropped by the IF/ID flush
          HZ_PC_out   = STALL;
          HZ_IFID_out = FLUSH;
          HZ_IDEX_out = dh ? FLUSH : NONE;
        end
        default: begin
          HZ_PC_out   = STALL;
          HZ_IFID_out = FLUSH;
          HZ_IDEX_out = FLUSH;
        end
      endcase
    end
  end

`ifdef HZU_PERF_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = EN & (HZ_PC_out == STALL);
  assign flush_evt = EN & BRANCH_cond_in;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      STALL_CNT_out <= '0;
      FLUSH_CNT_out <= '0;
    end else begin
      if (stall_evt && (STALL_CNT_out != {CNT_W{1'b1}})) begin
        STALL_CNT_out <= STALL_CNT_out + 1'b1;
      end
      if (flush_evt && (FLUSH_CNT_out != {CNT_W{1'b1}})) begin
        FLUSH_CNT_out <= FLUSH_CNT_out + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit, FWD_EN=1 and FWD_EN=0 instances
module tb_hazard_unit;
  import riscv_pkg::*;

  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] S = 2'd1;
  localparam logic [1:0] F = 2'd2;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       EN;
  logic       br, rv;
  logic [4:0] rs1, rs2, exrd, memrd;
  logic       u1, u2, exwr, exld, memwr;

  HAZARD_ctrl a_pc, a_ifid, a_idex;
  HAZARD_ctrl b_pc, b_ifid, b_idex;
`ifdef HZU_PERF_EN
  logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

  typedef struct {
    string      tag;
    logic [5:0] ea;
    logic [5:0] eb;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_vectors;
  int n_miscompares;

  always #5 CLK = ~CLK;

  hazard_unit #(.FWD_EN(1), .CNT_W(32)) u_dut_fwd (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .BRANCH_cond_in(br), .IMEM_RVALID_in(rv),
    .ID_RS1_in(rs1), .ID_RS2_in(rs2), .ID_USE_RS1_in(u1), .ID_USE_RS2_in(u2),
    .EX_RD_in(exrd), .EX_REGWR_in(exwr), .EX_MEMRD_in(exld),
    .MEM_RD_in(memrd), .MEM_REGWR_in(memwr),
    .HZ_PC_out(a_pc), .HZ_IFID_out(a_ifid), .HZ_IDEX_out(a_idex)
`ifdef HZU_PERF_EN
    , .STALL_CNT_out(a_stall_cnt), .FLUSH_CNT_out(a_flush_cnt)
`endif
  );

  hazard_unit #(.FWD_EN(0), .CNT_W(32)) u_dut_nofwd (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .BRANCH_cond_in(br), .IMEM_RVALID_in(rv),
    .ID_RS1_in(rs1), .ID_RS2_in(rs2), .ID_USE_RS1_in(u1), .ID_USE_RS2_in(u2),
    .EX_RD_in(exrd), .EX_REGWR_in(exwr), .EX_MEMRD_in(exld),
    .MEM_RD_in(memrd), .MEM_REGWR_in(memwr),
    .HZ_PC_out(b_pc), .HZ_IFID_out(b_ifid), .HZ_IDEX_out(b_idex)
`ifdef HZU_PERF_EN
    , .STALL_CNT_out(b_stall_cnt), .FLUSH_CNT_out(b_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    RSTn = 1'b1; EN = 1'b1; br = 1'b0; rv = 1'b1;
    rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
    exrd = 5'd0; exwr = 1'b0; exld = 1'b0; memrd = 5'd0; memwr = 1'b0;
  endtask

  // push the expectation with the stimulus, pop it when the outputs settle mid-cycle
  task automatic step(input string tag, input logic [5:0] ea, input logic [5:0] eb);
    sb_entry_t e;
    sb_q.push_back('{tag, ea, eb});
    @(negedge CLK);
    e = sb_q.pop_front();
    check({e.tag, "/fwd.pc"},     32'(a_pc),   32'(e.ea[5:4]));
    check({e.tag, "/fwd.ifid"},   32'(a_ifid), 32'(e.ea[3:2]));
    check({e.tag, "/fwd.idex"},   32'(a_idex), 32'(e.ea[1:0]));
    check({e.tag, "/nofwd.pc"},   32'(b_pc),   32'(e.eb[5:4]));
    check({e.tag, "/nofwd.ifid"}, 32'(b_ifid), 32'(e.eb[3:2]));
    check({e.tag, "/nofwd.idex"}, 32'(b_idex), 32'(e.eb[1:0]));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_vectors = 0;
    n_miscompares = 0;
    idle();
    RSTn = 1'b0;
    step("rst0", {F,F,F}, {F,F,F});
    br = 1'b1; rv = 1'b0;
    step("rst1_br", {F,F,F}, {F,F,F});
    idle();
    step("rel", {N,N,N}, {N,N,N});

    // load-use on rs1, then the load moves to MEM
    exrd = 5'd5; exwr = 1'b1; exld = 1'b1; rs1 = 5'd5; u1 = 1'b1;
    step("lduse", {S,S,F}, {S,S,F});
    exrd = 5'd0; exwr = 1'b0; exld = 1'b0; memrd = 5'd5; memwr = 1'b1;
    step("lduse_nxt", {N,N,N}, {S,S,F});
    idle();
    exrd = 5'd0; exwr = 1'b1; exld = 1'b1; rs1 = 5'd0; u1 = 1'b1;
    step("x0_ld", {N,N,N}, {N,N,N});
    idle();
    exrd = 5'd9; exwr = 1'b1; exld = 1'b0; rs2 = 5'd9; u2 = 1'b1;
    step("alu_raw", {N,N,N}, {S,S,F});
    u2 = 1'b0;
    step("rs2_unused", {N,N,N}, {N,N,N});
    idle();
    memrd = 5'd7; memwr = 1'b1; rs2 = 5'd7; u2 = 1'b1;
    step("mem_raw", {N,N,N}, {S,S,F});
    memrd = 5'd0;
    step("mem_x0", {N,N,N}, {N,N,N});

    // branch with outstanding fetch
    idle(); br = 1'b1; rv = 1'b0;
    step("br_n", {N,F,F}, {N,F,F});
    br = 1'b0;
    for (int i = 1; i <= 3; i++) step($sformatf("disc_n%0d", i), {S,F,N}, {S,F,N});
    rv = 1'b1;
    step("disc_drop", {S,F,N}, {S,F,N});
    step("disc_done", {N,N,N}, {N,N,N});

    // plain imem wait in RUN does not enter DISCARD
    rv = 1'b0;
    step("imem_wait", {S,F,N}, {S,F,N});
    rv = 1'b1;
    step("imem_ok", {N,N,N}, {N,N,N});
    br = 1'b1;
    step("br_rv", {N,F,F}, {N,F,F});
    br = 1'b0;
    step("br_rv_nxt", {N,N,N}, {N,N,N});

    // EN=0 freezes DISCARD
    br = 1'b1; rv = 1'b0;
    step("en_br", {N,F,F}, {N,F,F});
    br = 1'b0; EN = 1'b0; rv = 1'b1;
    step("en_off", {S,S,S}, {S,S,S});
    EN = 1'b1; rv = 1'b0;
    step("en_held", {S,F,N}, {S,F,N});
    rv = 1'b1;
    step("en_drop", {S,F,N}, {S,F,N});
    step("en_run", {N,N,N}, {N,N,N});

    // data hazard while discarding, and a second branch in DISCARD
    br = 1'b1; rv = 1'b0;
    step("dh_br", {N,F,F}, {N,F,F});
    br = 1'b0; exrd = 5'd5; exwr = 1'b1; exld = 1'b1; rs1 = 5'd5; u1 = 1'b1;
    step("disc_dh", {S,F,F}, {S,F,F});
    idle(); rv = 1'b0; br = 1'b1;
    step("disc_br", {N,F,F}, {N,F,F});
    br = 1'b0; rv = 1'b1;
    step("disc_br_drop", {S,F,N}, {S,F,N});
    step("disc_br_run", {N,N,N}, {N,N,N});

    // reset mid-DISCARD forgets the stale fetch
    br = 1'b1; rv = 1'b0;
    step("rd_br", {N,F,F}, {N,F,F});
    idle(); RSTn = 1'b0; EN = 1'b0;
    step("rd_rst", {F,F,F}, {F,F,F});
    idle();
    step("rd_run", {N,N,N}, {N,N,N});

`ifdef HZU_PERF_EN
    RSTn = 1'b0;
    step("pf_rst", {F,F,F}, {F,F,F});
    idle(); rv = 1'b0;
    for (int i = 0; i < 3; i++) step($sformatf("pf_stall%0d", i), {S,F,N}, {S,F,N});
    EN = 1'b0;
    for (int i = 0; i < 2; i++) step($sformatf("pf_en_off%0d", i), {S,S,S}, {S,S,S});
    EN = 1'b1; rv = 1'b1; br = 1'b1;
    step("pf_br", {N,F,F}, {N,F,F});
    idle();
    check("pf_stall_cnt_fwd",   a_stall_cnt, 32'd3);
    check("pf_flush_cnt_fwd",   a_flush_cnt, 32'd1);
    check("pf_stall_cnt_nofwd", b_stall_cnt, 32'd3);
    check("pf_flush_cnt_nofwd", b_flush_cnt, 32'd1);
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
